// File: rtl/forwarding_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit_if
//
// Groups the pipeline-facing signals of forwarding_hazard_unit.
//   master : pipeline side. Drives the ID/EX instruction info and the perf
//            clear. Receives the forward selects, the stall/flush/wait
//            controls and the stall counter.
//   slave  : the hazard unit itself.
//
// Packing of multi-port fields: port k sits at [k*REG_AW +: REG_AW] for
// register addresses and at [2*k +: 2] for forward selects.
// ---------------------------------------------------------------------------
interface forwarding_hazard_unit_if #(
    parameter int REG_AW       = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int CNT_W        = 16
);
    // ID stage
    logic                           id_valid_i;
    logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_i;
    logic [NUM_RD_PORTS-1:0]        id_rs_used_i;
    // EX stage
    logic                           ex_valid_i;
    logic [NUM_RD_PORTS*REG_AW-1:0] ex_rs_i;
    logic [REG_AW-1:0]              ex_rd_i;
    logic                           ex_regwrite_i;
    logic                           ex_load_i;
    // Performance counter control
    logic                           perf_clr_i;
    // Results
    logic [2*NUM_RD_PORTS-1:0]      fwd_sel_o;
    logic                           stall_if_id_o;
    logic                           flush_id_ex_o;
    logic                           mem_wait_o;
    logic [CNT_W-1:0]               stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rs_used_i,
        output ex_valid_i, ex_rs_i, ex_rd_i, ex_regwrite_i, ex_load_i,
        output perf_clr_i,
        input  fwd_sel_o, stall_if_id_o, flush_id_ex_o, mem_wait_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rs_used_i,
        input  ex_valid_i, ex_rs_i, ex_rd_i, ex_regwrite_i, ex_load_i,
        input  perf_clr_i,
        output fwd_sel_o, stall_if_id_o, flush_id_ex_o, mem_wait_o, stall_cnt_o
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit
//
// Forwarding and hazard control for an in-order pipeline. The unit keeps its
// own copy of the destination tags of the instructions in EX/MEM and MEM/WB,
// so the downstream pipeline registers do not have to feed RD back.
//
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : forwarding_hazard_unit_if.slave
//            inputs  - ID valid/sources/used mask, EX valid/sources/dest/
//                      regwrite/load, perf counter clear
//            outputs - per-port forward selects (10 EX/MEM, 01 MEM/WB,
//                      00 register file), stall_if_id_o, flush_id_ex_o,
//                      mem_wait_o, saturating stall cycle counter
//
// A load occupies MEM for MEM_LATENCY cycles; for the first MEM_LATENCY-1 of
// them mem_wait_o freezes the front of the pipeline and bubbles MEM/WB.
// ---------------------------------------------------------------------------
module forwarding_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int MEM_LATENCY  = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    forwarding_hazard_unit_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LATENCY - 1);

    // ---------------------------------------------------------------------
    // Tag registers and counters
    // ---------------------------------------------------------------------
    logic              em_valid_reg;
    logic [REG_AW-1:0] em_rd_reg;
    logic              em_regwrite_reg;
    logic              em_load_reg;
    logic              mw_valid_reg;
    logic [REG_AW-1:0] mw_rd_reg;
    logic              mw_regwrite_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;

    logic mem_wait;
    logic load_enter;
    logic load_use;
    logic stall;

    assign mem_wait   = (wait_cnt_reg != '0);
    // A load only enters EX/MEM when the pipeline is not frozen.
    assign load_enter = bus.ex_valid_i & bus.ex_load_i & ~mem_wait;

    // ---------------------------------------------------------------------
    // Forward selects: EX/MEM (younger) wins over MEM/WB. A load in EX/MEM
    // has no data yet, so it never forwards from there.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_fwd
            logic [REG_AW-1:0] rs;
            logic              em_hit;
            logic              mw_hit;

            assign rs     = bus.ex_rs_i[gi*REG_AW +: REG_AW];
            assign em_hit = em_valid_reg & em_regwrite_reg & ~em_load_reg &
                            (em_rd_reg != '0) & (em_rd_reg == rs);
            assign mw_hit = mw_valid_reg & mw_regwrite_reg &
                            (mw_rd_reg != '0) & (mw_rd_reg == rs);

            assign bus.fwd_sel_o[2*gi +: 2] = em_hit ? 2'b10 :
                                              mw_hit ? 2'b01 : 2'b00;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Load-use detection against the load currently in EX
    // ---------------------------------------------------------------------
    logic [NUM_RD_PORTS-1:0] port_hit;

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_lu
            assign port_hit[gi] = bus.id_rs_used_i[gi] &
                                  (bus.id_rs_i[gi*REG_AW +: REG_AW] == bus.ex_rd_i);
        end
    endgenerate

    // Gated by reset so that every control output is quiet while in reset.
    assign load_use = ~rst_i & bus.id_valid_i & bus.ex_valid_i & bus.ex_load_i &
                      bus.ex_regwrite_i & (bus.ex_rd_i != '0) & (|port_hit);

    // The memory wait already holds ID/EX, so no bubble is inserted during
    // it; the load-use is simply seen again once the wait releases.
    assign stall             = load_use | mem_wait;
    assign bus.stall_if_id_o = stall;
    assign bus.flush_id_ex_o = load_use & ~mem_wait;
    assign bus.mem_wait_o    = mem_wait;
    assign bus.stall_cnt_o   = stall_cnt_reg;

    // ---------------------------------------------------------------------
    // Next-state logic for the counters
    // ---------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (load_enter) begin
            wait_cnt_next = WAIT_LOAD;
        end else if (mem_wait) begin
            wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (bus.perf_clr_i) begin
            stall_cnt_next = '0;
        end else if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Tag pipeline: advances with the real pipeline, holds EX/MEM and
    // bubbles MEM/WB while a multi-cycle load sits in MEM.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            em_valid_reg    <= 1'b0;
            em_rd_reg       <= '0;
            em_regwrite_reg <= 1'b0;
            em_load_reg     <= 1'b0;
            mw_valid_reg    <= 1'b0;
            mw_rd_reg       <= '0;
            mw_regwrite_reg <= 1'b0;
        end else if (!mem_wait) begin
            em_valid_reg    <= bus.ex_valid_i;
            em_rd_reg       <= bus.ex_rd_i;
            em_regwrite_reg <= bus.ex_regwrite_i;
            em_load_reg     <= bus.ex_load_i;
            mw_valid_reg    <= em_valid_reg;
            mw_rd_reg       <= em_rd_reg;
            mw_regwrite_reg <= em_regwrite_reg;
        end else begin
            mw_valid_reg    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Parametrised successor of the pipeline forwarding logic.
- Tracks in-flight destination tags across EX, EX/MEM and MEM/WB internally, so downstream pipeline registers need not feed back their RD fields.
- Produces per-read-port forward selects, a load-use stall/bubble pair and a multi-cycle data-memory wait freeze.
- Sits beside the ID/EX/MEM/WB registers and drives their enables, the ID/EX flush and the EX operand muxes; keeps a stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- NUM_RD_PORTS, 2, number of source operands per instruction (N).
- MEM_LATENCY, 1, cycles a load occupies MEM; must be >= 1.
- CNT_W, 16, stall performance counter width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- id_valid_i  input  1  ID holds a valid instruction.
- id_rs_i  input  N*REG_AW  ID source registers; port k at [k*REG_AW +: REG_AW].
- id_rs_used_i  input  N  per-port: source actually read.
- ex_valid_i  input  1  EX holds a valid instruction (0 = bubble).
- ex_rs_i  input  N*REG_AW  EX source registers, same packing.
- ex_rd_i  input  REG_AW  EX destination.
- ex_regwrite_i  input  1  EX instruction writes RD.
- ex_load_i  input  1  EX instruction is a load.
- perf_clr_i  input  1  synchronous clear of stall_cnt_o.
- fwd_sel_o  output  2*N  per-port select: 2'b10 from EX/MEM, 2'b01 from MEM/WB, 2'b00 register file; 2'b11 never driven.
- stall_if_id_o  output  1  hold PC and IF/ID.
- flush_id_ex_o  output  1  load bubble into ID/EX.
- mem_wait_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- stall_cnt_o  output  CNT_W  saturating stall-cycle count.

Behaviour:
- Internal tag registers: em_{valid,rd,regwrite,load} for EX/MEM and mw_{valid,rd,regwrite} for MEM/WB, plus wait_cnt of width $clog2(MEM_LATENCY+1).
- Reset (async, rst_i=1): all tag valids 0, wait_cnt 0, stall_cnt_o 0.
- Reset outputs: fwd_sel_o all 0, stall_if_id_o 0, flush_id_ex_o 0, mem_wait_o 0.
- Reset asserted mid-wait or mid-stall aborts it immediately; there is no residual freeze after release.
- mem_wait_o = (wait_cnt != 0); combinational from the register.
- Tag advance on each rising edge when mem_wait_o = 0:
  - em <= {ex_valid_i, ex_rd_i, ex_regwrite_i, ex_load_i}.
  - mw <= em.
- Tag advance when mem_wait_o = 1: em holds; mw_valid <= 0 (bubble).
- wait_cnt:
  - Loads MEM_LATENCY-1 on the edge where a valid load enters em (ex_valid_i & ex_load_i & ~mem_wait_o).
  - Otherwise decrements while nonzero.
  - MEM_LATENCY=1 means no wait is ever asserted.
  - A load needs MEM_LATENCY cycles in MEM; the pipeline resumes on the cycle after wait_cnt reaches 0.
- Forward select, per port k, combinational, using ex_rs_i port k (rs):
  - 2'b10 when em_valid & em_regwrite & ~em_load & em_rd != 0 & em_rd == rs.
  - Else 2'b01 when mw_valid & mw_regwrite & mw_rd != 0 & mw_rd == rs.
  - Else 2'b00.
  - A younger EX/MEM match always beats MEM/WB. rs = 0 always yields 2'b00.
- Load-use, combinational:
  - hit = id_valid_i & ex_valid_i & ex_load_i & ex_regwrite_i & ex_rd_i != 0, and any port k has id_rs_used_i[k] & id_rs_i[k] == ex_rd_i.
  - stall_if_id_o = hit | mem_wait_o.
  - flush_id_ex_o = hit & ~mem_wait_o.
  - Exactly one stall cycle per load-use with MEM_LATENCY=1, after which the value forwards from MEM/WB (2'b01).
- Simultaneous events:
  - mem_wait_o dominates: flush is suppressed during a wait, and load-use is re-evaluated once the wait ends.
  - Ports whose id_rs_used_i bit is 0 never cause a stall.
- stall_cnt_o:
  - perf_clr_i has priority: clears to 0.
  - Else increments by 1 when stall_if_id_o is 1.
  - Saturates at all-ones without wrapping.

Test Plan:
- ADD x5 in EX (ex_rd_i=5, regwrite); next cycle EX reads rs1=5, rs2=5 -> fwd_sel_o=4'b1010.
- x5 written by both EX/MEM and MEM/WB, EX rs1=5 -> port0 select 2'b10 (priority). Same with rd=0 and rs1=0 -> 2'b00.
- LW x7 in EX, ID reads rs2=7 with used=1, MEM_LATENCY=1 -> one cycle stall_if_id_o=1, flush_id_ex_o=1. Consumer then reaches EX with port1 select 2'b01. With used=0 -> no stall.
- MEM_LATENCY=3: LW enters EX/MEM -> mem_wait_o=1 for exactly 2 cycles, em tags held, mw bubbled, stall_cnt_o +2. A load-use pending in ID during the wait -> flush only after the wait ends.
- Assert rst_i while wait_cnt=2 -> all outputs 0 at once, no wait after release.
- CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated); perf_clr_i coincident with a stall -> 0.
